// File: rtl/karatsuba_dot_acc_if.sv
// karatsuba_dot_acc_if: product-in / dot-product-out valid/ready bundle.
interface karatsuba_dot_acc_if #(
    parameter int PW    = 4,
    parameter int ACC_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [PW-1:0]    prod;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;
    modport master (output in_valid, prod, out_ready, input in_ready, out_valid, out_sum, out_ovf);
    modport slave  (input in_valid, prod, out_ready, output in_ready, out_valid, out_sum, out_ovf);
endinterface

// File: rtl/karatsuba_dot_acc.sv
// karatsuba_dot_acc: saturating accumulator summing VLEN unsigned products into
// one dot-product result, with a per-vector sticky overflow flag.
module karatsuba_dot_acc #(
    parameter int PW    = 4,
    parameter int VLEN  = 8,
    parameter int ACC_W = 12,
    parameter int CW    = $clog2(VLEN)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    karatsuba_dot_acc_if.slave s
);
    typedef enum logic {ACCUM, HOLD} state_t;
    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d, sat;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d, sovf_q, sovf_d;
    logic [ACC_W:0]   add;
    logic             accept, last;
    assign add    = {1'b0, acc_q} + {{(ACC_W + 1 - PW){1'b0}}, s.prod};
    assign sat    = add[ACC_W] ? '1 : add[ACC_W-1:0];
    assign accept = (state_q == ACCUM) && s.in_valid;
    assign last   = cnt_q == CW'(VLEN - 1);
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        sum_d   = sum_q;
        sovf_d  = sovf_q;
        if (clr) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (accept && last) begin
            state_d = HOLD;
            sum_d   = sat;
            sovf_d  = ovf_q | add[ACC_W];
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (accept) begin
            acc_d = sat;
            cnt_d = cnt_q + CW'(1);
            ovf_d = ovf_q | add[ACC_W];
        end else if (state_q == HOLD && s.out_ready) begin
            state_d = ACCUM;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sum_q   <= '0;
            sovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            sum_q   <= sum_d;
            sovf_q  <= sovf_d;
        end
    end
    // Handshake outputs come straight from the state register.
    assign s.in_ready  = state_q == ACCUM;
    assign s.out_valid = state_q == HOLD;
    assign s.out_sum   = sum_q;
    assign s.out_ovf   = sovf_q;
endmodule

// File: doc/karatsuba_dot_acc.md
# karatsuba_dot_acc

Streaming accumulator directly downstream of the `karatsuba2` multiplier. It takes one unsigned product per accepted beat over a valid/ready handshake and sums exactly `VLEN` products into one dot-product result. The result is then presented on a valid/ready output port, which feeds the accelerator's activation/writeback stage. Accumulation saturates, and a sticky overflow flag is kept per vector.

## Interface
- `PW`, default 4: product width; matches the 4-bit `karatsuba2` output, unsigned.
- `VLEN`, default 8: products per dot product; must be ≥ 2.
- `ACC_W`, default 12: accumulator and result width; must be ≥ `PW`.
- `CW`, default `$clog2(VLEN)`: element counter width.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clr` input 1: synchronous abort of the current vector.
- `in_valid` input 1: product beat valid.
- `in_ready` output 1: block can accept a product.
- `prod` input `PW`: unsigned product from the multiplier.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_sum` output `ACC_W`: saturated dot-product result.
- `out_ovf` output 1: high if any saturation occurred in this vector.

## Operation
- One clock and one reset: `clk`, plus `rst_n` (asynchronous assert, active-low). All state is registered on rising `clk`.
- Two-state FSM:
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Accept in ACCUM (`in_valid & in_ready`):
  - `acc <= sat(acc + zext(prod))`, where `sat` clamps at 2^ACC_W−1.
  - `ovf <= ovf | carry`.
  - `cnt <= cnt+1`.
- Last element: an accept with `cnt==VLEN-1` does the following at that edge:
  - writes the final sum to `out_sum` and the final flag to `out_ovf`;
  - resets `acc`=0, `cnt`=0, `ovf`=0;
  - moves the FSM to HOLD.
- HOLD:
  - `out_sum` and `out_ovf` are frozen.
  - When `out_ready`=1, the FSM returns to ACCUM at that edge and `out_valid` drops.
  - The next vector's first beat can be accepted on the following cycle at the earliest.
- `in_valid` gaps (bubbles) are allowed anywhere in a vector; `cnt` advances only on an accept.
- `clr`=1 has priority over everything. At that edge: `acc`=0, `cnt`=0, `ovf`=0, FSM to ACCUM, `out_valid`=0, and any held result is discarded. A beat presented in the same cycle is dropped, not accumulated.
- Reset values:
  - `acc`=0, `cnt`=0, `ovf`=0, state ACCUM.
  - `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_ovf`=0.
- Once saturated, the accumulator stays at max for the rest of the vector.

## Timing
- Latency: `out_valid` rises one cycle after the edge that accepted the `VLEN`-th beat.
- Throughput: `VLEN` beats per `VLEN+1` cycles minimum, because HOLD always lasts at least 1 cycle.
- `in_ready` and `out_valid` are pure functions of the FSM state: registered, with no combinational path from `in_valid` or `out_ready`.
- `out_sum` and `out_ovf` do not change while `out_valid`=1, except under `clr` or reset.
- `rst_n` low mid-vector: all state clears immediately, asynchronously. The partial sum is lost, and the first beat after release starts a new vector at `cnt`=0.
- Zero-valued products count as elements. A vector of all zeros yields `out_sum`=0, `out_ovf`=0.

## Test plan
- Basic vector: defaults, eight back-to-back beats with `prod`=9 and `out_ready`=1 → `out_valid` one cycle after beat 8, `out_sum`=72, `out_ovf`=0, `in_ready` low for exactly 1 cycle.
- Bubbles and backpressure: beats 1..8 (`prod`=1..8) with `in_valid` low on alternate cycles, `out_ready` held low for 5 cycles → `out_sum`=36 held stable, `in_ready`=0 throughout HOLD, and the next vector is accepted only after the handshake.
- Saturation: `ACC_W`=6, eight beats of 9 → `out_sum`=63, `out_ovf`=1. A following vector of eight 1s → `out_sum`=8, `out_ovf`=0 (the flag does not carry over).
- Clear: `clr` pulsed after 4 beats of 5, in the same cycle as a beat of 7 → that beat is ignored. Then 8 beats of 2 → `out_sum`=16.
- Clear in HOLD: `clr` asserted while `out_valid`=1 → `out_valid`=0 next cycle, `in_ready`=1, and the held result is never handshaken.
- Reset mid-vector: assert `rst_n` low after 3 beats → `out_sum`=0, `in_ready`=1 immediately. After release, 8 beats of 3 → `out_sum`=24.
